// File: rtl/loopback_pkg.sv
// Shared types and helpers for the stream loopback engine.
// The saturating increment works on a 32-bit value, so counters can be up to 32 bits wide.
package loopback_pkg;

  typedef enum logic {
    MODE_PASS  = 1'b0,
    MODE_BURST = 1'b1
  } mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } burst_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
    logic [32:0] limit;
    limit = (33'd1 << width) - 33'd1;
    return (value == limit[31:0]) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/loopback_fifo.sv
// Circular FIFO with a registered read port, so it maps onto block RAM.
// The pointers wrap modulo DEPTH; occupancy, empty and full are registered.
module loopback_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic [ADDR_WIDTH:0]   occupancy,
  output logic                  empty,
  output logic                  full
);

  localparam logic [ADDR_WIDTH:0]   ONE        = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;

  // The memory has no reset, so synthesis can infer block RAM for it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // When the FIFO is full, a write and a read can hit the same address.
  // The read returns the old contents, which is the oldest entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_ptr];
    end
  end

  always_comb begin
    count_next = count;
    if (wr_en && !rd_en) begin
      count_next = count + ONE;
    end else if (!wr_en && rd_en) begin
      count_next = count - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == FULL_COUNT);
    end
  end

  assign occupancy = count;

endmodule

// File: rtl/stream_loopback_engine.sv
// Source mux, FIFO buffering, burst/pass output control and debug statistics
// for the UART loopback path.
//
//   state    | meaning
//   ST_IDLE  | BURST mode: FIFO loads blocked, waiting for occupancy >= threshold
//   ST_DRAIN | BURST mode: loads permitted until FIFO and output register are empty
module stream_loopback_engine
  import loopback_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_SRC    = 3,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = 16,
  parameter int SEL_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [SEL_W-1:0]         src_sel,
  input  logic                     mode,
  input  logic [ADDR_WIDTH:0]      threshold,
  input  logic                     tx_enable,
  input  logic                     flush,
  output logic [WIDTH-1:0]         tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [ADDR_WIDTH:0]      occupancy,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic [CNT_WIDTH-1:0]     in_count,
  output logic [CNT_WIDTH-1:0]     out_count,
  output logic [CNT_WIDTH-1:0]     drop_count
);

  mode_t               mode_e;
  burst_state_t        state;
  burst_state_t        state_next;
  logic                sel_valid;
  logic [WIDTH-1:0]    sel_data;
  logic [ADDR_WIDTH:0] thr_eff;
  logic                load_ok;
  logic                pop;
  logic                wr_en;
  logic                drop;
  logic                xfer;
  logic                tx_valid_next;

  assign mode_e  = mode_t'(mode);
  assign thr_eff = (threshold == '0) ? {{ADDR_WIDTH{1'b0}}, 1'b1} : threshold;

  // A src_sel value with no matching source leaves sel_valid low.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_sel == SEL_W'(i)) begin
        sel_valid = src_valid[i];
        sel_data  = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    xfer          = tx_valid && tx_ready;
    load_ok       = (mode_e == MODE_PASS) || (state == ST_DRAIN);
    pop           = !flush && !empty && tx_enable && (!tx_valid || tx_ready) && load_ok;
    wr_en         = sel_valid && !flush && (!full || pop);
    drop          = sel_valid && !flush && full && !pop;
    tx_valid_next = pop ? 1'b1 : (xfer ? 1'b0 : tx_valid);
  end

  always_comb begin
    state_next = state;
    if (mode_e == MODE_PASS) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (occupancy >= thr_eff) state_next = ST_DRAIN;
        ST_DRAIN: if (occupancy == '0 && !tx_valid_next) state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tx_valid   <= 1'b0;
      overflow   <= 1'b0;
      in_count   <= '0;
      out_count  <= '0;
      drop_count <= '0;
    end else begin
      state    <= flush ? ST_IDLE : state_next;
      tx_valid <= flush ? 1'b0 : tx_valid_next;
      overflow <= flush ? 1'b0 : (overflow || drop);
      // The statistics survive a flush; only reset clears them.
      if (wr_en) begin
        in_count <= CNT_WIDTH'(sat_inc(32'(in_count), CNT_WIDTH));
      end
      if (xfer) begin
        out_count <= CNT_WIDTH'(sat_inc(32'(out_count), CNT_WIDTH));
      end
      if (drop) begin
        drop_count <= CNT_WIDTH'(sat_inc(32'(drop_count), CNT_WIDTH));
      end
    end
  end

  loopback_fifo #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .wr_en     (wr_en),
    .wr_data   (sel_data),
    .rd_en     (pop),
    .rd_data   (tx_data),
    .occupancy (occupancy),
    .empty     (empty),
    .full      (full)
  );

endmodule

// File: tb/tb_stream_loopback_engine.sv
// Scoreboard bench for stream_loopback_engine: stimulus pushes expected bytes,
// and a negedge monitor checks every tx transfer against the queue.
module tb_stream_loopback_engine;

  localparam int WIDTH   = 8;
  localparam int NUM_SRC = 3;
  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int CW      = 16;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]       src_valid;
  logic [1:0]               src_sel;
  logic                     mode;
  logic [AW:0]              threshold;
  logic                     tx_enable;
  logic                     flush;
  logic [WIDTH-1:0]         tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  logic [AW:0]              occupancy;
  logic                     empty;
  logic                     full;
  logic                     overflow;
  logic [CW-1:0]            in_count;
  logic [CW-1:0]            out_count;
  logic [CW-1:0]            drop_count;

  logic [7:0] sb[$];
  logic [7:0] mon_exp;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_loopback_engine #(
    .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .src_data(src_data), .src_valid(src_valid),
    .src_sel(src_sel), .mode(mode), .threshold(threshold), .tx_enable(tx_enable),
    .flush(flush), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .occupancy(occupancy), .empty(empty), .full(full), .overflow(overflow),
    .in_count(in_count), .out_count(out_count), .drop_count(drop_count)
  );

  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL tx_unexpected: got %h, expected no transfer", tx_data);
      end else begin
        mon_exp = sb.pop_front();
        if (tx_data !== mon_exp) begin
          n_err++;
          $display("FAIL tx_data: got %h, expected %h", tx_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input int s, input logic [7:0] d, input bit store);
    src_data  = 24'(d) << (s * WIDTH);
    src_valid = 3'(1 << s);
    if (store) sb.push_back(d);
    tick();
    src_valid = '0;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0 && !tx_valid && occupancy == '0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s: drain timeout, queue=%0d occupancy=%0d, expected 0/0", name, sb.size(), occupancy);
    end
  endtask

  initial begin
    rst_n = 1'b0; src_data = '0; src_valid = '0; src_sel = 2'd0; mode = 1'b0;
    threshold = '0; tx_enable = 1'b1; flush = 1'b0; tx_ready = 1'b1;
    repeat (3) tick();
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_in_count", 32'(in_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // PASS streaming with the one-cycle read latency
    send(0, 8'h41, 1);
    chk("lat_pre_valid", 32'(tx_valid), 32'd0);
    chk("lat_pre_occ", 32'(occupancy), 32'd1);
    send(0, 8'h42, 1);
    chk("lat_post_valid", 32'(tx_valid), 32'd1);
    send(0, 8'h43, 1);
    drain("pass_drain");
    chk("pass_out_count", 32'(out_count), 32'd3);
    chk("pass_empty", 32'(empty), 32'd1);

    // Source select
    src_sel = 2'd2;
    src_data = {8'h22, 8'h00, 8'h11};
    src_valid = 3'b101;
    sb.push_back(8'h22);
    tick();
    src_valid = '0;
    drain("sel_drain");
    chk("sel_in_count", 32'(in_count), 32'd4);
    src_sel = 2'd3;
    src_data = {8'h33, 8'h22, 8'h11};
    src_valid = 3'b111;
    tick();
    src_valid = '0;
    tick();
    chk("sel3_in_count", 32'(in_count), 32'd4);
    chk("sel3_occ", 32'(occupancy), 32'd0);
    src_sel = 2'd0;

    // Overflow, then a write and a pop in the same cycle while full
    tx_enable = 1'b0;
    for (int i = 0; i < 10; i++) send(0, 8'(8'h50 + i), i < 8);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_occ", 32'(occupancy), 32'd8);
    chk("ovf_drop", 32'(drop_count), 32'd2);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_in_count", 32'(in_count), 32'd12);
    tx_enable = 1'b1;
    send(0, 8'h5A, 1);
    chk("fullrw_occ", 32'(occupancy), 32'd8);
    chk("fullrw_valid", 32'(tx_valid), 32'd1);
    chk("fullrw_drop", 32'(drop_count), 32'd2);
    chk("fullrw_in_count", 32'(in_count), 32'd13);
    drain("ovf_drain");
    chk("ovf_out_count", 32'(out_count), 32'd13);

    // BURST with threshold 4
    mode = 1'b1;
    threshold = 4'd4;
    for (int i = 0; i < 3; i++) send(0, 8'(8'h61 + i), 1);
    repeat (5) tick();
    chk("burst_hold_valid", 32'(tx_valid), 32'd0);
    chk("burst_hold_occ", 32'(occupancy), 32'd3);
    send(0, 8'h64, 1);
    drain("burst_drain");
    send(0, 8'h65, 1);
    repeat (5) tick();
    chk("burst_idle_valid", 32'(tx_valid), 32'd0);
    chk("burst_idle_occ", 32'(occupancy), 32'd1);
    send(0, 8'h66, 1);
    send(0, 8'h67, 1);
    repeat (3) tick();
    chk("burst_3_valid", 32'(tx_valid), 32'd0);
    send(0, 8'h68, 1);
    drain("burst_drain2");
    chk("burst_out_count", 32'(out_count), 32'd21);

    // Flush mid-stream
    mode = 1'b0;
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(0, 8'(8'h80 + i), 0);
    chk("preflush_occ", 32'(occupancy), 32'd5);
    chk("preflush_valid", 32'(tx_valid), 32'd1);
    chk("preflush_ovf", 32'(overflow), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_occ", 32'(occupancy), 32'd0);
    chk("flush_valid", 32'(tx_valid), 32'd0);
    chk("flush_ovf", 32'(overflow), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_in_count", 32'(in_count), 32'd27);
    chk("flush_out_count", 32'(out_count), 32'd21);
    chk("flush_drop", 32'(drop_count), 32'd2);

    // Reset while draining in BURST
    mode = 1'b1;
    threshold = 4'd2;
    for (int i = 0; i < 3; i++) send(0, 8'(8'h90 + i), 0);
    repeat (2) tick();
    chk("drain_valid", 32'(tx_valid), 32'd1);
    chk("drain_occ", 32'(occupancy), 32'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_valid", 32'(tx_valid), 32'd0);
    chk("mrst_occ", 32'(occupancy), 32'd0);
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_in_count", 32'(in_count), 32'd0);
    chk("mrst_out_count", 32'(out_count), 32'd0);
    chk("mrst_drop", 32'(drop_count), 32'd0);
    chk("mrst_ovf", 32'(overflow), 32'd0);
    tx_ready = 1'b1;
    send(0, 8'hA1, 1);
    repeat (4) tick();
    chk("mrst_idle_valid", 32'(tx_valid), 32'd0);
    mode = 1'b0;
    drain("mrst_drain");

    // Backpressure
    tx_ready = 1'b0;
    send(0, 8'h71, 1);
    send(0, 8'h72, 1);
    send(0, 8'h73, 1);
    repeat (2) tick();
    chk("bp_valid", 32'(tx_valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      chk("bp_data", 32'(tx_data), 32'h71);
      chk("bp_occ", 32'(occupancy), 32'd2);
      tick();
    end
    tx_ready = 1'b1;
    drain("bp_drain");
    chk("end_in_count", 32'(in_count), 32'd4);
    chk("end_out_count", 32'(out_count), 32'd4);
    chk("end_empty", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
